// File: rtl/free_list.sv
// Circular free list of physical register indices for rename.
// Flush rolls the allocation head back to the committed point.
module free_list #(
  parameter int unsigned NUM_PR = 64,
  parameter int unsigned NUM_AR = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alloc_req,
  output logic                              alloc_valid,
  output logic [$clog2(NUM_PR)-1:0]         alloc_pd,
  input  logic                              free_we,
  input  logic [$clog2(NUM_PR)-1:0]         free_pd,
  input  logic                              flush,
  output logic [$clog2(NUM_PR-NUM_AR):0]    free_count
);

  localparam int unsigned PR_WIDTH = $clog2(NUM_PR);
  localparam int unsigned DEPTH    = NUM_PR - NUM_AR;
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned PTR_W    = IDX_W + 1;

  logic [PR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [PTR_W-1:0]    arch_head;

  logic [PTR_W-1:0]    count;
  logic                empty;
  logic                full;
  logic                do_alloc;
  logic                do_free;

  always_comb begin
    count    = tail - head;
    empty    = (tail == head);
    full     = (tail[IDX_W-1:0] == head[IDX_W-1:0]) && (tail[IDX_W] != head[IDX_W]);
    do_alloc = alloc_req && !empty && !flush;
    do_free  = free_we && !full;
  end

  assign alloc_valid = !empty;
  assign alloc_pd    = mem[head[IDX_W-1:0]];
  assign free_count  = count;

  // tail - arch_head stays at DEPTH, so reloading head from arch_head refills the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= PR_WIDTH'(int'(NUM_AR) + i);
      end
      head      <= '0;
      arch_head <= '0;
      tail      <= {1'b1, IDX_W'(0)};
    end else begin
      if (do_free) begin
        mem[tail[IDX_W-1:0]] <= free_pd;
        tail                 <= tail + PTR_W'(1);
        arch_head            <= arch_head + PTR_W'(1);
      end
      if (flush) begin
        head <= arch_head + PTR_W'(do_free);
      end else if (do_alloc) begin
        head <= head + PTR_W'(1);
      end
    end
  end

  // Returning a pd into a full queue means commit and rename disagree.
  free_when_full_a: assert property (@(posedge clk) disable iff (rst) free_we |-> !full);

endmodule
